// File: rtl/mips_pkg.sv
// mips_pkg: shared immediate widths and extension-mode encoding for the MIPS datapath.
package mips_pkg;
    localparam int IMM_W  = 16;
    localparam int WORD_W = 32;
    typedef enum logic [1:0] {
        EXT_SIGN   = 2'd0,
        EXT_ZERO   = 2'd1,
        EXT_LUI    = 2'd2,
        EXT_BRANCH = 2'd3
    } ext_mode_t;
endpackage

// File: rtl/sign_extend_if.sv
// sign_extend_if: immediate request from the instruction register and registered extended result.
interface sign_extend_if #(
    parameter int IN_W  = mips_pkg::IMM_W,
    parameter int OUT_W = mips_pkg::WORD_W
);
    logic [IN_W-1:0]  in_data;
    logic [1:0]       ext_mode;
    logic             in_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    modport master (output in_data, ext_mode, in_valid, input out_data, out_valid);
    modport slave  (input in_data, ext_mode, in_valid, output out_data, out_valid);
endinterface

// File: rtl/sign_extend_core.sv
// sign_extend_core: combinational mode mux widening an immediate to a datapath word.
module sign_extend_core
    import mips_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = WORD_W
) (
    input  logic [IN_W-1:0]  imm_i,
    input  logic [1:0]       mode_i,
    output logic [OUT_W-1:0] ext_o
);
    logic [OUT_W-1:0] sext;
    assign sext = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};
    // Unknown modes fall to the default arm so they behave as SIGN.
    always_comb begin
        ext_o = sext;
        case (mode_i)
            EXT_ZERO:   ext_o = {{(OUT_W-IN_W){1'b0}}, imm_i};
            EXT_LUI:    ext_o = {imm_i, {(OUT_W-IN_W){1'b0}}};
            EXT_BRANCH: ext_o = {sext[OUT_W-3:0], 2'b00};
            default:    ext_o = sext;
        endcase
    end
endmodule

// File: rtl/sign_extend.sv
// sign_extend: ID-stage immediate extension with a one-cycle registered result and valid flag.
module sign_extend
    import mips_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = WORD_W
) (
    input logic         clk,
    input logic         rst,
    sign_extend_if.slave bus
);
    logic [OUT_W-1:0] ext, data_q, data_d;
    logic             valid_q, valid_d;

    sign_extend_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
        .imm_i  (bus.in_data),
        .mode_i (bus.ext_mode),
        .ext_o  (ext)
    );

    always_comb begin
        data_d  = bus.in_valid ? ext : data_q;
        valid_d = bus.in_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_sign_extend.sv
// tb_sign_extend: directed spec vectors plus randomized traffic against an arithmetic reference.
module tb_sign_extend;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [31:0] md = '0;
    logic        mv = 1'b0;

    sign_extend_if #(.IN_W(16), .OUT_W(32)) bus ();
    sign_extend dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_ext(input logic [15:0] d, input int m);
        int s;
        s = int'($signed(d));
        case (m)
            1:       return 32'(int'(d));
            2:       return 32'(int'(d) * 65536);
            3:       return 32'(s * 4);
            default: return 32'(s);
        endcase
    endfunction

    task automatic drive(input logic [15:0] d, input logic [1:0] m, input logic v);
        bus.in_data  = d;
        bus.ext_mode = m;
        bus.in_valid = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] ed, input logic ev);
        checks++;
        assert (bus.out_data === ed) else begin
            failures++;
            $error("FAIL %s out_data got=%h exp=%h", tag, bus.out_data, ed);
        end
        checks++;
        assert (bus.out_valid === ev) else begin
            failures++;
            $error("FAIL %s out_valid got=%b exp=%b", tag, bus.out_valid, ev);
        end
    endtask

    initial begin
        logic [15:0] sin[5]  = '{16'h0000, 16'h1234, 16'hFFFF, 16'h8000, 16'h7FFF};
        logic [31:0] sout[5] = '{32'h00000000, 32'h00001234, 32'hFFFFFFFF, 32'hFFFF8000, 32'h00007FFF};
        logic [31:0] mout[3] = '{32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFC};
        drive(16'hFFFF, 2'd0, 1'b1);
        rst = 1'b1;
        tick();
        chk("reset0", 32'h0, 1'b0);
        tick();
        chk("reset1", 32'h0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(sin[i], 2'd0, 1'b1);
            tick();
            chk($sformatf("sign%0d", i), sout[i], 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            drive(16'hFFFF, 2'(i + 1), 1'b1);
            tick();
            chk($sformatf("mode%0d", i + 1), mout[i], 1'b1);
        end
        drive(16'h1234, 2'd2, 1'b1);
        tick();
        chk("lui1234", 32'h12340000, 1'b1);
        drive(16'h0001, 2'd3, 1'b1);
        tick();
        chk("branch1", 32'h00000004, 1'b1);
        drive(16'h7FFF, 2'd3, 1'b1);
        tick();
        chk("branch7fff", 32'h0001FFFC, 1'b1);
        drive(16'h1234, 2'd0, 1'b1);
        tick();
        chk("hold_load", 32'h00001234, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(i[0] ? 16'h0000 : 16'hFFFF, 2'd1, 1'b0);
            tick();
            chk($sformatf("hold%0d", i), 32'h00001234, 1'b0);
        end
        drive(16'h8000, 2'd0, 1'b1);
        tick();
        chk("mid_load", 32'hFFFF8000, 1'b1);
        rst = 1'b1;
        tick();
        chk("mid_rst", 32'h0, 1'b0);
        rst = 1'b0;
        drive(16'h0001, 2'd3, 1'b1);
        tick();
        chk("post_rst", 32'h00000004, 1'b1);
        md = 32'h00000004;
        mv = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] d;
            int m;
            logic v, r;
            d = 16'($urandom);
            m = int'($urandom_range(3));
            v = 1'($urandom_range(1));
            r = ($urandom_range(39) == 0);
            drive(d, 2'(m), v);
            rst = r;
            tick();
            if (r) begin
                md = '0;
                mv = 1'b0;
            end else begin
                if (v) md = ref_ext(d, m);
                mv = v;
            end
            chk($sformatf("rand%0d", i), md, mv);
        end
        rst = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
